// File: rtl/set_cursor_control.sv
// set_cursor_control: set-mode controller for the clock/stopwatch display.
// Turns debounced buttons into a set-mode flag, a field cursor, one-cycle
// per-field up/down step pulses and a blink enable for the selected field.
// Exits set mode after TIMEOUT cycles without any button edge.
//
// Optional feature macro: AUTO_REPEAT_EN (held up/down auto-repeat).
//
// Ports:
//   i_clk, i_rstn                      clock, async active-low reset
//   i_set, i_up, i_down, i_left, i_right  button levels (synchronized, debounced)
//   o_set_mode                         high while editing
//   o_cursor                           selected field: 0=ms 1=sec 2=min 3=hr
//   o_blink                            blink enable, 0 outside edit
//   o_{ms,sec,min,hr}_{up,down}        one-cycle step pulses
module set_cursor_control #(
    parameter int unsigned REPEAT_DELAY  = 500,
    parameter int unsigned REPEAT_PERIOD = 100,
    parameter int unsigned TIMEOUT       = 10000,
    parameter int unsigned BLINK_HALF    = 250
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_set,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    output logic       o_set_mode,
    output logic [1:0] o_cursor,
    output logic       o_blink,
    output logic       o_ms_up,
    output logic       o_ms_down,
    output logic       o_sec_up,
    output logic       o_sec_down,
    output logic       o_min_up,
    output logic       o_min_down,
    output logic       o_hr_up,
    output logic       o_hr_down
);

    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    // Elaboration-time parameter range checks
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be >= 2");
    end
    if (BLINK_HALF < 1) begin : g_bad_blink
        $error("BLINK_HALF must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EDIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic set_q, up_q, down_q, left_q, right_q;
    logic set_e, up_e, down_e, left_e, right_e, any_edge;
    logic timeout_hit;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
    logic [1:0]      cursor_d;
    logic            blink_d;
    logic [7:0]      steps_q, steps_d;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

    logic [RP_W-1:0] rep_cnt_q, rep_cnt_d, rep_limit;
    logic            rep_armed_q, rep_armed_d;
`endif

    assign set_e    = i_set & ~set_q;
    assign up_e     = i_up & ~up_q;
    assign down_e   = i_down & ~down_q;
    assign left_e   = i_left & ~left_q;
    assign right_e  = i_right & ~right_q;
    assign any_edge = set_e | up_e | down_e | left_e | right_e;

    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT - 1)) && !any_edge;

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (set_e) state_d = S_EDIT;
            S_EDIT: if (set_e || timeout_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of outputs and counters
    always_comb begin
        logic dir_one, edge_now, fire, cursor_chg;
        cursor_d   = o_cursor;
        blink_d    = 1'b0;
        bl_cnt_d   = '0;
        to_cnt_d   = '0;
        steps_d    = '0;
        fire       = 1'b0;
        cursor_chg = 1'b0;
        // Only a lone up or lone down may step; both together cancel
        dir_one    = i_up ^ i_down;
        edge_now   = i_up ? up_e : down_e;
`ifdef AUTO_REPEAT_EN
        rep_cnt_d   = '0;
        rep_armed_d = 1'b0;
        rep_limit   = rep_armed_q ? RP_W'(REPEAT_PERIOD - 1) : RP_W'(REPEAT_DELAY - 1);
`endif
        if (state_q == S_IDLE) begin
            if (state_d == S_EDIT) begin
                cursor_d = 2'd3;
                blink_d  = 1'b1;
            end
        end else if (state_d == S_EDIT) begin
            to_cnt_d = any_edge ? '0 : to_cnt_q + TO_W'(1);

            if (bl_cnt_q == BL_W'(BLINK_HALF - 1)) begin
                bl_cnt_d = '0;
                blink_d  = ~o_blink;
            end else begin
                bl_cnt_d = bl_cnt_q + BL_W'(1);
                blink_d  = o_blink;
            end

            if (left_e && !right_e) begin
                cursor_d   = o_cursor + 2'd1;
                cursor_chg = 1'b1;
            end else if (right_e && !left_e) begin
                cursor_d   = o_cursor - 2'd1;
                cursor_chg = 1'b1;
            end

`ifdef AUTO_REPEAT_EN
            if (!dir_one) begin
                rep_cnt_d   = '0;
                rep_armed_d = 1'b0;
            end else if (edge_now) begin
                fire        = 1'b1;
                rep_cnt_d   = '0;
                rep_armed_d = 1'b0;
            end else if (rep_cnt_q == rep_limit) begin
                fire        = 1'b1;
                rep_cnt_d   = '0;
                rep_armed_d = 1'b1;
            end else begin
                rep_cnt_d   = rep_cnt_q + RP_W'(1);
                rep_armed_d = rep_armed_q;
            end
            if (cursor_chg) begin
                rep_cnt_d   = '0;
                rep_armed_d = 1'b0;
            end
`else
            fire = dir_one & edge_now;
`endif
            // Pulse targets the field selected before this cycle's cursor move
            steps_d[{o_cursor, 1'b0}] = fire & i_up;
            steps_d[{o_cursor, 1'b1}] = fire & i_down;
        end
    end

    // Output, counter and previous-value registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            set_q       <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            o_set_mode  <= 1'b0;
            o_cursor    <= 2'd3;
            o_blink     <= 1'b0;
            steps_q     <= '0;
            to_cnt_q    <= '0;
            bl_cnt_q    <= '0;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
`endif
        end else begin
            set_q       <= i_set;
            up_q        <= i_up;
            down_q      <= i_down;
            left_q      <= i_left;
            right_q     <= i_right;
            o_set_mode  <= (state_d == S_EDIT);
            o_cursor    <= cursor_d;
            o_blink     <= blink_d;
            steps_q     <= steps_d;
            to_cnt_q    <= to_cnt_d;
            bl_cnt_q    <= bl_cnt_d;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
`endif
        end
    end

    assign o_ms_up    = steps_q[0];
    assign o_ms_down  = steps_q[1];
    assign o_sec_up   = steps_q[2];
    assign o_sec_down = steps_q[3];
    assign o_min_up   = steps_q[4];
    assign o_min_down = steps_q[5];
    assign o_hr_up    = steps_q[6];
    assign o_hr_down  = steps_q[7];

endmodule

// File: tb/tb_set_cursor_control.sv
// tb_set_cursor_control: directed-vector bench for set_cursor_control.
// Works with AUTO_REPEAT_EN defined or undefined.
module tb_set_cursor_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       b_set, b_up, b_down, b_left, b_right;
    logic       set_mode, blink;
    logic [1:0] cursor;
    logic       ms_up, ms_down, sec_up, sec_down, min_up, min_down, hr_up, hr_down;
    logic [7:0] steps;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    set_cursor_control #(
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(4),
        .TIMEOUT      (50),
        .BLINK_HALF   (5)
    ) dut (
        .i_clk     (clk),
        .i_rstn    (rst_n),
        .i_set     (b_set),
        .i_up      (b_up),
        .i_down    (b_down),
        .i_left    (b_left),
        .i_right   (b_right),
        .o_set_mode(set_mode),
        .o_cursor  (cursor),
        .o_blink   (blink),
        .o_ms_up   (ms_up),
        .o_ms_down (ms_down),
        .o_sec_up  (sec_up),
        .o_sec_down(sec_down),
        .o_min_up  (min_up),
        .o_min_down(min_down),
        .o_hr_up   (hr_up),
        .o_hr_down (hr_down)
    );

    assign steps = {hr_down, hr_up, min_down, min_up, sec_down, sec_up, ms_down, ms_up};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive buttons {right,left,down,up,set} for one sampled cycle, then release
    task automatic press(input logic [4:0] btn);
        {b_right, b_left, b_down, b_up, b_set} = btn;
        tick();
        {b_right, b_left, b_down, b_up, b_set} = 5'b0;
    endtask

    initial begin
        logic [1:0] exp_cur [5];
        logic       exp_pulse;
        exp_cur[0] = 2'd0; exp_cur[1] = 2'd1; exp_cur[2] = 2'd2;
        exp_cur[3] = 2'd3; exp_cur[4] = 2'd0;

        rst_n = 1'b0;
        {b_right, b_left, b_down, b_up, b_set} = 5'b0;
        #23;
        check("rst_set_mode", 32'(set_mode), 32'd0);
        check("rst_cursor",   32'(cursor),   32'd3);
        check("rst_blink",    32'(blink),    32'd0);
        check("rst_steps",    32'(steps),    32'd0);
        rst_n = 1'b1;
        tick();

        // Enter edit, blink pattern 1x5 then 0x5
        press(5'b00001);
        check("enter_set_mode", 32'(set_mode), 32'd1);
        check("enter_cursor",   32'(cursor),   32'd3);
        check("enter_blink",    32'(blink),    32'd1);
        check("enter_steps",    32'(steps),    32'd0);
        for (int k = 1; k < 10; k++) begin
            tick();
            check("blink_phase", 32'(blink), (k < 5) ? 32'd1 : 32'd0);
            check("blink_steps", 32'(steps), 32'd0);
        end

        // Cursor: five left edges, one right, then left+right together
        for (int i = 0; i < 5; i++) begin
            press(5'b01000);
            check("left_cursor", 32'(cursor), 32'(exp_cur[i]));
            tick();
        end
        press(5'b10000);
        check("right_cursor", 32'(cursor), 32'd3);
        tick();
        press(5'b11000);
        check("left_right_cursor", 32'(cursor), 32'd3);
        tick();

        // Move to sec, then step
        press(5'b01000); tick();
        press(5'b01000); tick();
        check("cursor_sec", 32'(cursor), 32'd1);
        press(5'b00010);
        check("sec_up_pulse", 32'(steps), 32'h04);
        tick();
        check("sec_up_one_cycle", 32'(steps), 32'h00);
        press(5'b01010);
        check("up_left_pulse",  32'(steps),  32'h04);
        check("up_left_cursor", 32'(cursor), 32'd2);
        tick();
        press(5'b00110);
        check("up_down_none", 32'(steps), 32'h00);
        tick();
        check("up_down_none2", 32'(steps), 32'h00);

        // Held up at min: auto-repeat timing or single pulse
        b_up = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
`ifdef AUTO_REPEAT_EN
            exp_pulse = (k == 0) || (k >= 8 && ((k - 8) % 4) == 0);
`else
            exp_pulse = (k == 0);
`endif
            check("hold_min_up", 32'(steps), exp_pulse ? 32'h10 : 32'h00);
        end
        b_up = 1'b0;
        tick();
        check("hold_release", 32'(steps), 32'h00);
        check("hold_still_edit", 32'(set_mode), 32'd1);

        // Timeout with right held across the window
        b_right = 1'b1;
        tick();
        check("to_cursor", 32'(cursor), 32'd1);
        for (int k = 1; k <= 50; k++) begin
            tick();
            check("to_set_mode", 32'(set_mode), (k < 50) ? 32'd1 : 32'd0);
        end
        check("to_blink", 32'(blink), 32'd0);
        b_right = 1'b0;
        tick();
        press(5'b01000);
        check("idle_ignore_left", 32'(cursor),   32'd1);
        check("idle_stay",        32'(set_mode), 32'd0);
        tick();

        // Set edge with an up edge while editing: exit, no pulse
        press(5'b00001);
        check("reenter_cursor", 32'(cursor), 32'd3);
        tick();
        press(5'b00011);
        check("exit_set_mode", 32'(set_mode), 32'd0);
        check("exit_steps",    32'(steps),    32'd0);
        tick();

        // Async reset mid-edit with up held
        press(5'b00001); tick();
        press(5'b01000); tick();
        b_up = 1'b1;
        tick();
        check("pre_rst_pulse", 32'(steps), 32'h01);
        #2 rst_n = 1'b0;
        #1;
        check("async_set_mode", 32'(set_mode), 32'd0);
        check("async_cursor",   32'(cursor),   32'd3);
        check("async_blink",    32'(blink),    32'd0);
        check("async_steps",    32'(steps),    32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle",  32'(set_mode), 32'd0);
        check("post_rst_steps", 32'(steps),    32'd0);
        b_up = 1'b0;
        tick();
        press(5'b00001);
        check("post_rst_enter",  32'(set_mode), 32'd1);
        check("post_rst_cursor", 32'(cursor),   32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/set_cursor_control.md
# set_cursor_control

Set-mode controller for the clock/stopwatch display. It turns the debounced i_set/i_up/i_down/i_left/i_right buttons into a set-mode flag, a field cursor, and single-cycle per-field up/down pulses. Those pulses drive the ms/sec/min/hr digit counters directly, in the same way as the stopwatch controller's o_*_up/o_*_down outputs. It also supplies the blink enable for the selected field and exits set mode on inactivity.

## Interface
- REPEAT_DELAY, 500, cycles an up/down button must be held before auto-repeat starts (>=1)
- REPEAT_PERIOD, 100, cycles between auto-repeat pulses (>=1)
- TIMEOUT, 10000, cycles without any button edge before EDIT exits to IDLE (>=2)
- BLINK_HALF, 250, cycles per blink phase (>=1)
- i_clk  in  1  system clock; all logic on posedge
- i_rstn  in  1  asynchronous, active-low reset
- i_set, i_up, i_down, i_left, i_right  in  1 each  button levels, already synchronized and debounced upstream
- o_set_mode  out  1  high while in EDIT
- o_cursor  out  2  selected field: 0=ms, 1=sec, 2=min, 3=hr
- o_blink  out  1  blink enable for the selected field; 0 outside EDIT
- o_ms_up, o_ms_down, o_sec_up, o_sec_down, o_min_up, o_min_down, o_hr_up, o_hr_down  out  1 each  one-cycle step pulses

## Operation
- Each button has a previous-value register; "edge" means the input is sampled 1 while the previous value is 0.
- States:
  - IDLE (reset state)
  - EDIT
- IDLE:
  - set edge -> EDIT, cursor = 3 (hr), blink phase = 1, timeout counter cleared.
  - All other buttons ignored.
- EDIT, by priority:
  - set edge -> IDLE; no step pulse is issued that cycle.
  - Timeout counter reaches TIMEOUT-1 with no edge on any button -> IDLE.
  - Left edge -> cursor+1, wrapping 3->0. Right edge -> cursor-1, wrapping 0->3. Left and right edges together -> cursor unchanged.
  - Up edge -> up pulse on the field selected before any cursor update that same cycle. Down works the same way.
  - Up and down both high (edge or held) -> no pulse, repeat counter cleared.
- Any button edge clears the timeout counter.
- Held buttons do not reset the timeout. Auto-repeat pulses do not reset it either.
- Exactly one of the eight step outputs may be high in any cycle.
- Blink counter free-runs modulo BLINK_HALF in EDIT. o_blink toggles on each wrap. The counter is held at 0 in IDLE.
- Counter widths are $clog2 of the respective parameter, minimum 1 bit. Counters saturate or wrap only as specified and never overflow silently.

## Timing
- All outputs are registered.
- A step pulse is high for exactly one cycle, in the cycle following the clock edge that samples the button edge.
- o_set_mode and o_cursor update at that same edge (1-cycle latency).
- Reset values:
  - state IDLE, o_set_mode 0, o_cursor 3, o_blink 0
  - all step outputs 0, all counters 0
  - previous-value registers 0
- Reset asserted mid-operation clears everything asynchronously. A button held through reset release produces an edge on the first sampled cycle.
- Auto-repeat (AUTO_REPEAT_EN):
  - The initial edge pulse counts as pulse 0.
  - With the button held, the next pulse comes REPEAT_DELAY cycles after pulse 0, then one every REPEAT_PERIOD cycles.
  - Releasing the button, a cursor change, or leaving EDIT clears the repeat counter.

## Configuration
- AUTO_REPEAT_EN defined: held-button auto-repeat as described under Timing.
- AUTO_REPEAT_EN undefined:
  - Only edges produce step pulses.
  - The repeat counter and its parameters are unused and no logic is generated for them.
  - All other behaviour is identical.

## Test plan
Bench parameters: REPEAT_DELAY=8, REPEAT_PERIOD=4, TIMEOUT=50, BLINK_HALF=5.
- Reset, then pulse i_set for 1 cycle -> o_set_mode=1 and o_cursor=3 one cycle later; o_blink=1 for 5 cycles, then 0 for 5 cycles; no step pulse.
- In EDIT at cursor 3, five left edges -> cursor sequence 0,1,2,3,0. Then one right edge -> 3. Left and right edges in the same cycle -> cursor unchanged.
- In EDIT at cursor 1, up edge -> o_sec_up high for exactly 1 cycle. Up and left edges in the same cycle -> o_sec_up pulse, cursor becomes 2. Up and down together -> no pulses.
- AUTO_REPEAT_EN, cursor 2, i_up held 30 cycles -> o_min_up pulses at relative cycles 0, 8, 12, 16, 20, 24, 28 (7 pulses). Without the macro -> 1 pulse.
- Enter EDIT, then no edges for 50 cycles -> o_set_mode drops, o_blink=0. A button held across the window does not prevent the exit.
- i_rstn asserted while in EDIT with i_up held -> all outputs immediately take their reset values. After release, set edge -> EDIT with cursor=3.
